// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct
// fields, ALU control codes, the FSM state enum and the ALU op enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's alu_op plus the R-type funct field onto the 3-bit ALU control.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_ADD;
                    FN_SUB:  alu_control = ALUC_SUB;
                    FN_AND:  alu_control = ALUC_AND;
                    FN_OR:   alu_control = ALUC_OR;
                    FN_SLT:  alu_control = ALUC_SLT;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath; drives every select and
// write enable each cycle and folds the branch/zero condition into pc_en.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter bit ADDI_EN = 1'b1,
    parameter bit JUMP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_write, branch, ir_write_s, mem_write_s, reg_write_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        alu_op      = ALUOP_ADD;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = ADDI_EN ? S_ADDIEXEC : S_FETCH;
                    OP_J:         state_d = JUMP_EN ? S_JUMP : S_FETCH;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            // Unused encodings drive no enables and fall back to FETCH.
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    // Reset blocks every architectural write even though the state decode is already FETCH.
    assign pc_en     = (pc_write | (branch & zero)) & ~reset;
    assign ir_write  = ir_write_s & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign reg_write = reg_write_s & ~reset;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class cycle by
// cycle and compares the full output vector against hand-built expectations.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    int checks = 0;
    int errors = 0;

    // {pc_en,iord,ir_write,mem_write,reg_write,reg_dst,mem_to_reg,alu_src_a,alu_src_b,pc_src,alu_control}
    logic [14:0] outs;
    assign outs = {pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, pc_src, alu_control};

    localparam logic [14:0] E_RST    = 15'b0_0_0_0_0_0_0_0_01_00_010;
    localparam logic [14:0] E_FETCH  = 15'b1_0_1_0_0_0_0_0_01_00_010;
    localparam logic [14:0] E_DECODE = 15'b0_0_0_0_0_0_0_0_11_00_010;
    localparam logic [14:0] E_MEMADR = 15'b0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [14:0] E_MEMRD  = 15'b0_1_0_0_0_0_0_0_00_00_010;
    localparam logic [14:0] E_MEMWB  = 15'b0_0_0_0_1_0_1_0_00_00_010;
    localparam logic [14:0] E_MEMWR  = 15'b0_1_0_1_0_0_0_0_00_00_010;
    localparam logic [14:0] E_EXEC0  = 15'b0_0_0_0_0_0_0_1_00_00_000;
    localparam logic [14:0] E_ALUWB  = 15'b0_0_0_0_1_1_0_0_00_00_010;
    localparam logic [14:0] E_BR_T   = 15'b1_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] E_BR_NT  = 15'b0_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] E_ADDIWB = 15'b0_0_0_0_1_0_0_0_00_00_010;
    localparam logic [14:0] E_JUMP   = 15'b1_0_0_0_0_0_0_0_00_10_010;

    mips_mc_controller #(.ADDI_EN(1'b1), .JUMP_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .iord        (iord),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control)
    );

    always #5 clk = ~clk;

    // Every task starts and ends at a falling edge with the FSM in FETCH.
    task automatic test_reset();
        #1;
        checks++;
        if (outs !== E_RST) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", outs, E_RST);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== E_FETCH) begin
            errors++;
            $display("FAIL reset_release got %b want %b", outs, E_FETCH);
        end
        @(negedge clk);
        op = 6'b111111;
        @(negedge clk);
    endtask

    task automatic test_lw();
        logic [14:0] exp [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL lw_cyc%0d got %b want %b", i, outs, exp[i]);
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_sw();
        logic [14:0] exp [5] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        op = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL sw_cyc%0d got %b want %b", i, outs, exp[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        logic [2:0] ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        logic [14:0] exp [5];
        op = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            funct = fn[k];
            exp = '{E_FETCH, E_DECODE, {E_EXEC0[14:3], ac[k]}, E_ALUWB, E_FETCH};
            for (int i = 0; i < 5; i++) begin
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    errors++;
                    $display("FAIL rtype_f%0d_cyc%0d got %b want %b", k, i, outs, exp[i]);
                end
                if (i < 4) @(negedge clk);
            end
        end
    endtask

    task automatic test_beq();
        logic [14:0] exp [4];
        op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            exp = '{E_FETCH, E_DECODE, z[0] ? E_BR_T : E_BR_NT, E_FETCH};
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    errors++;
                    $display("FAIL beq_z%0d_cyc%0d got %b want %b", z, i, outs, exp[i]);
                end
                if (i < 3) @(negedge clk);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_addi();
        logic [14:0] exp [5] = '{E_FETCH, E_DECODE, E_MEMADR, E_ADDIWB, E_FETCH};
        op = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL addi_cyc%0d got %b want %b", i, outs, exp[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_jump();
        logic [14:0] exp [4] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        op = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL jump_cyc%0d got %b want %b", i, outs, exp[i]);
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_unsupported();
        logic [14:0] exp [3] = '{E_FETCH, E_DECODE, E_FETCH};
        op = 6'b111111;
        zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL nop_cyc%0d got %b want %b", i, outs, exp[i]);
            end
            if (i < 2) @(negedge clk);
        end
        zero = 1'b0;
    endtask

    // Assert reset in the middle of MEMRD, away from any clock edge.
    task automatic test_reset_mid();
        op = 6'b100011;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (outs !== E_MEMRD) begin
            errors++;
            $display("FAIL mid_memrd got %b want %b", outs, E_MEMRD);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (outs !== E_RST) begin
            errors++;
            $display("FAIL mid_async got %b want %b", outs, E_RST);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== E_RST) begin
            errors++;
            $display("FAIL mid_held got %b want %b", outs, E_RST);
        end
        @(negedge clk);
        op = 6'b111111;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== E_FETCH) begin
            errors++;
            $display("FAIL mid_release got %b want %b", outs, E_FETCH);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== E_DECODE) begin
            errors++;
            $display("FAIL mid_decode got %b want %b", outs, E_DECODE);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops [3] = '{6'b000010, 6'b000100, 6'b111111};
        logic [14:0] exp [3] = '{E_JUMP, E_BR_NT, E_FETCH};
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            @(negedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (outs !== exp[k]) begin
                errors++;
                $display("FAIL b2b_%0d got %b want %b", k, outs, exp[k]);
            end
            if (k < 2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi();
        test_jump();
        test_unsupported();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
